imem_arbiter: RTL

//  Shares the single-port instruction memory between the fetch stage (read-only) and the

---
 rtl/imem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Per-cycle arbiter for the single-port instruction memory.
//               It shares the memory between fetch (read-only) and the
//               loader/debug port (read/write) and offers a lock mode that
//               keeps fetch off the memory while an image is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int MEM_WORDS    = 128,
    parameter int AW           = 7,
    parameter int MAX_LD_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_i,
    input  logic [31:0]   if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [31:0]   if_rdata_o,
    output logic          if_err_o,
    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic [31:0]   ld_addr_i,
    input  logic [31:0]   ld_wdata_i,
    input  logic          ld_lock_i,
    output logic          ld_gnt_o,
    output logic          ld_rvalid_o,
    output logic [31:0]   ld_rdata_o,
    output logic          ld_err_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          locked_o
);

    localparam int            C_SW         = $clog2(MAX_LD_BURST + 1);
    localparam logic [C_SW-1:0] C_STREAK_MAX = C_SW'(MAX_LD_BURST);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [C_SW-1:0] r_streak;
    logic [C_SW-1:0] w_streak_nxt;
    logic            r_if_pend;
    logic            r_ld_pend;
    logic            r_err;
    logic            r_ld_we;
    logic            w_if_gnt;
    logic            w_ld_gnt;
    logic            w_fetch_wins;
    logic            w_if_err;
    logic            w_ld_err;
    logic            w_err_sel;
    logic            w_any_gnt;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(MEM_WORDS));
    endfunction

    // Loader normally wins; fetch only breaks in after a full loader streak.
    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        w_fetch_wins = 1'b0;
        w_ld_gnt     = 1'b0;
        w_if_gnt     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ld_lock_i) begin
                    w_state_nxt = ST_LOCKED;
                end
                w_fetch_wins = if_req_i && (r_streak == C_STREAK_MAX);
                w_ld_gnt     = ld_req_i && !w_fetch_wins;
                w_if_gnt     = if_req_i && !w_ld_gnt;
                if (!if_req_i || w_if_gnt) begin
                    w_streak_nxt = '0;
                end else if (w_ld_gnt && (r_streak != C_STREAK_MAX)) begin
                    w_streak_nxt = r_streak + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!ld_lock_i) begin
                    w_state_nxt = ST_RUN;
                end
                w_ld_gnt     = ld_req_i;
                w_streak_nxt = '0;
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_streak_nxt = '0;
            end
        endcase
    end

    assign w_if_err  = addr_bad(if_addr_i);
    assign w_ld_err  = addr_bad(ld_addr_i);
    assign w_any_gnt = w_if_gnt || w_ld_gnt;
    assign w_err_sel = w_ld_gnt ? w_ld_err : w_if_err;

    assign if_gnt_o    = w_if_gnt;
    assign ld_gnt_o    = w_ld_gnt;
    assign mem_en_o    = w_any_gnt && !w_err_sel;
    assign mem_we_o    = mem_en_o && w_ld_gnt && ld_we_i;
    assign mem_addr_o  = !mem_en_o ? '0 :
                         (w_ld_gnt ? ld_addr_i[AW+1:2] : if_addr_i[AW+1:2]);
    assign mem_wdata_o = mem_we_o ? ld_wdata_i : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_streak  <= '0;
            r_if_pend <= 1'b0;
            r_ld_pend <= 1'b0;
            r_err     <= 1'b0;
            r_ld_we   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_streak  <= w_streak_nxt;
            r_if_pend <= w_if_gnt;
            r_ld_pend <= w_ld_gnt;
            r_err     <= w_any_gnt && w_err_sel;
            r_ld_we   <= w_ld_gnt && ld_we_i;
        end
    end

    // Read data is steered only to the owner; errors and writes return zero.
    assign if_rvalid_o = r_if_pend;
    assign if_err_o    = r_if_pend && r_err;
    assign if_rdata_o  = (r_if_pend && !r_err) ? mem_rdata_i : '0;
    assign ld_rvalid_o = r_ld_pend;
    assign ld_err_o    = r_ld_pend && r_err;
    assign ld_rdata_o  = (r_ld_pend && !r_err && !r_ld_we) ? mem_rdata_i : '0;
    assign locked_o    = (r_state == ST_LOCKED);

endmodule
`default_nettype wire
